// File: rtl/i2c_target_resp.sv
// I2C target: 2-FF synchronized scl/sda, START/STOP detection, 7-bit address match, byte write/read.
// Define I2C_TARGET_FILTER_EN to insert a 3-sample majority filter after the synchronizer.
module i2c_target_resp #(
  parameter logic [6:0] TARGET_ADDR = 7'h55
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
  } state_t;

  logic [1:0] scl_sync, sda_sync;
  logic       scl_s, sda_s;
  logic       scl_f, sda_f;
  logic       scl_d, sda_d;

  // NOTE: sequential state is assigned with <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
    end
  end

  assign scl_s = scl_sync[1];
  assign sda_s = sda_sync[1];

`ifdef I2C_TARGET_FILTER_EN
  logic [1:0] scl_hist, sda_hist;

  // Majority of the current and two previous samples; a 1-cycle pulse never wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_hist <= 2'b11;
      sda_hist <= 2'b11;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[0], scl_s};
      sda_hist <= {sda_hist[0], sda_s};
      scl_f    <= (scl_s & scl_hist[0]) | (scl_s & scl_hist[1]) | (scl_hist[0] & scl_hist[1]);
      sda_f    <= (sda_s & sda_hist[0]) | (sda_s & sda_hist[1]) | (sda_hist[0] & sda_hist[1]);
    end
  end
`else
  assign scl_f = scl_s;
  assign sda_f = sda_s;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_rise  = scl_f & ~scl_d;
  assign scl_fall  = ~scl_f & scl_d;
  assign start_det = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic [7:0] rx_data_nxt;
  logic       nack, nack_nxt;
  logic       oe_nxt, busy_nxt, rx_valid_nxt, tx_load;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    shreg_nxt    = shreg;
    nack_nxt     = nack;
    oe_nxt       = sda_oe;
    busy_nxt     = busy;
    rx_data_nxt  = rx_data;
    rx_valid_nxt = 1'b0;
    tx_load      = 1'b0;

    if (stop_det) begin
      state_nxt = IDLE;
      cnt_nxt   = 4'd0;
      oe_nxt    = 1'b0;
      busy_nxt  = 1'b0;
    end else if (start_det) begin
      state_nxt = ADDR;
      cnt_nxt   = 4'd0;
      oe_nxt    = 1'b0;
      busy_nxt  = 1'b0;
    end else begin
      unique case (state)
        IDLE: oe_nxt = 1'b0;

        ADDR: begin
          if (scl_rise && cnt < 4'd8) begin
            shreg_nxt = {shreg[6:0], sda_f};
            cnt_nxt   = cnt + 4'd1;
          end else if (scl_fall && cnt == 4'd8) begin
            if (shreg[7:1] == TARGET_ADDR) begin
              oe_nxt    = 1'b1;
              busy_nxt  = 1'b1;
              state_nxt = ADDR_ACK;
            end else begin
              state_nxt = IGNORE;
            end
          end
        end

        // The counter runs 0..8 for data and reaches 9 on the ACK bit, then wraps to 0.
        ADDR_ACK: begin
          if (scl_rise && cnt == 4'd8) begin
            cnt_nxt = 4'd9;
          end else if (scl_fall && cnt == 4'd9) begin
            cnt_nxt = 4'd0;
            if (shreg[0]) begin
              tx_load   = 1'b1;
              shreg_nxt = tx_data;
              oe_nxt    = ~tx_data[7];
              state_nxt = RD_BYTE;
            end else begin
              oe_nxt    = 1'b0;
              state_nxt = WR_BYTE;
            end
          end
        end

        WR_BYTE: begin
          if (scl_rise && cnt < 4'd8) begin
            shreg_nxt = {shreg[6:0], sda_f};
            cnt_nxt   = cnt + 4'd1;
          end else if (scl_fall && cnt == 4'd8) begin
            rx_data_nxt  = shreg;
            rx_valid_nxt = 1'b1;
            oe_nxt       = 1'b1;
            state_nxt    = WR_ACK;
          end
        end

        WR_ACK: begin
          if (scl_rise && cnt == 4'd8) begin
            cnt_nxt = 4'd9;
          end else if (scl_fall && cnt == 4'd9) begin
            cnt_nxt   = 4'd0;
            oe_nxt    = 1'b0;
            state_nxt = WR_BYTE;
          end
        end

        RD_BYTE: begin
          if (scl_rise && cnt < 4'd8) begin
            cnt_nxt = cnt + 4'd1;
          end else if (scl_fall && cnt == 4'd8) begin
            oe_nxt    = 1'b0;
            state_nxt = RD_ACK;
          end else if (scl_fall && cnt != 4'd0) begin
            shreg_nxt = {shreg[6:0], 1'b0};
            oe_nxt    = ~shreg[6];
          end
        end

        RD_ACK: begin
          if (scl_rise && cnt == 4'd8) begin
            nack_nxt = sda_f;
            cnt_nxt  = 4'd9;
          end else if (scl_fall && cnt == 4'd9) begin
            cnt_nxt = 4'd0;
            if (!nack) begin
              tx_load   = 1'b1;
              shreg_nxt = tx_data;
              oe_nxt    = ~tx_data[7];
              state_nxt = RD_BYTE;
            end else begin
              oe_nxt    = 1'b0;
              busy_nxt  = 1'b0;
              state_nxt = IGNORE;
            end
          end
        end

        IGNORE: oe_nxt = 1'b0;

        default: begin
          state_nxt = IDLE;
          oe_nxt    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      shreg    <= 8'h00;
      nack     <= 1'b0;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      shreg    <= shreg_nxt;
      nack     <= nack_nxt;
      sda_oe   <= oe_nxt;
      busy     <= busy_nxt;
      rx_data  <= rx_data_nxt;
      rx_valid <= rx_valid_nxt;
    end
  end

  // tx_data is captured on the same edge where this pulse is high.
  assign tx_req = tx_load & ~rst;

endmodule

// File: tb/tb_i2c_target_resp.sv
// Bench for i2c_target_resp: an initiator model drives scl/sda; expectations come from address match and byte lists.
module tb_i2c_target_resp;

  localparam int         Q   = 4;
  localparam logic [6:0] TGT = 7'h55;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_drv = 1'b1;
  logic       sda_drv = 1'b1;
  logic       sda_oe, tx_req, rx_valid, busy;
  logic [7:0] tx_data, rx_data;
  wire        sda_line = sda_drv & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_resp #(.TARGET_ADDR(TGT)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (scl_drv),
    .sda_i    (sda_line),
    .sda_oe   (sda_oe),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] rx_q[$];
  int         tx_cnt = 0;
  bit         oe_seen = 1'b0;
  int         bad_pulse = 0;
  logic       prev_rx = 1'b0;
  logic       prev_tx = 1'b0;

  always @(negedge clk) begin
    if (rx_valid) rx_q.push_back(rx_data);
    if (tx_req) tx_cnt++;
    if (sda_oe) oe_seen = 1'b1;
    if ((rx_valid && tx_req) || (rx_valid && prev_rx) || (tx_req && prev_tx)) bad_pulse++;
    prev_rx = rx_valid;
    prev_tx = tx_req;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer_bit(input logic b, output logic s);
    sda_drv = b;
    wait_clks(Q);
    scl_drv = 1'b1;
    wait_clks(Q);
    s = sda_line;
    wait_clks(Q);
    scl_drv = 1'b0;
    wait_clks(Q);
  endtask

  task automatic byte_out(input logic [7:0] b, output logic [7:0] rd);
    for (int i = 7; i >= 0; i--) xfer_bit(b[i], rd[i]);
  endtask

  task automatic i2c_start();
    sda_drv = 1'b1;
    wait_clks(Q);
    scl_drv = 1'b1;
    wait_clks(Q);
    sda_drv = 1'b0;
    wait_clks(Q);
    scl_drv = 1'b0;
    wait_clks(Q);
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0;
    wait_clks(Q);
    scl_drv = 1'b1;
    wait_clks(Q);
    sda_drv = 1'b1;
    wait_clks(Q);
  endtask

  logic [7:0] txn_data[4];

  // One transaction; the target acks iff addr matches, writes land in rx order, reads return txn_data.
  task automatic run_txn(input logic [6:0] addr, input logic rw, input int n,
                         input bit do_stop, input string tag);
    logic       ack;
    logic [7:0] rd;
    bit         match;
    logic [7:0] exp_q[$];
    match = (addr == TGT);
    rx_q.delete();
    tx_cnt  = 0;
    oe_seen = 1'b0;
    if (rw) tx_data = txn_data[0];
    i2c_start();
    byte_out({addr, rw}, rd);
    xfer_bit(1'b1, ack);
    check({tag, "_addr_ack"}, ack, !match);
    check({tag, "_busy"}, busy, match);
    for (int i = 0; i < n; i++) begin
      if (!rw) begin
        byte_out(txn_data[i], rd);
        xfer_bit(1'b1, ack);
        check($sformatf("%s_wack%0d", tag, i), ack, !match);
        if (match) exp_q.push_back(txn_data[i]);
      end else begin
        byte_out(8'hFF, rd);
        check($sformatf("%s_rd%0d", tag, i), rd, match ? txn_data[i] : 8'hFF);
        if (i < n - 1) tx_data = txn_data[i + 1];
        xfer_bit(i == n - 1, ack);
      end
    end
    if (do_stop) begin
      wait_clks(Q);
      check({tag, "_busy_pre_stop"}, busy, match && !rw);
      i2c_stop();
      wait_clks(2 * Q);
      check({tag, "_busy_post_stop"}, busy, 0);
    end
    check({tag, "_oe_seen"}, oe_seen, match);
    check({tag, "_rx_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check($sformatf("%s_rx%0d", tag, i), rx_q[i], exp_q[i]);
    check({tag, "_tx_req_count"}, tx_cnt, (match && rw) ? n : 0);
  endtask

  initial begin
    logic       s, ack;
    logic [7:0] rd;
    logic [7:0] gbyte;
    logic [6:0] ra;
    int         k;

    rst     = 1'b1;
    tx_data = 8'h00;
    wait_clks(3);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_tx_req", tx_req, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    wait_clks(4);

    txn_data[0] = 8'hAA;
    run_txn(7'h55, 1'b0, 1, 1'b1, "wr_aa");

    txn_data[0] = 8'h11;
    run_txn(7'h54, 1'b0, 1, 1'b1, "nomatch");

    txn_data[0] = 8'hC3;
    txn_data[1] = 8'h3C;
    run_txn(7'h55, 1'b1, 2, 1'b1, "rd");

    txn_data[0] = 8'h12;
    run_txn(7'h55, 1'b0, 1, 1'b0, "rs_wr");
    txn_data[0] = 8'h5A;
    run_txn(7'h55, 1'b1, 1, 1'b1, "rs_rd");

    // Reset while the target is pulling sda low inside a read byte.
    tx_data = 8'h00;
    i2c_start();
    byte_out({TGT, 1'b1}, rd);
    xfer_bit(1'b1, ack);
    check("rstmid_addr_ack", ack, 0);
    xfer_bit(1'b1, s);
    check("rstmid_bit7", s, 0);
    k = 0;
    while (!sda_oe && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("rstmid_pre_oe", sda_oe, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_post_oe", sda_oe, 0);
    check("rstmid_post_busy", busy, 0);
    rst = 1'b0;
    wait_clks(4);
    i2c_stop();
    wait_clks(2 * Q);
    txn_data[0] = 8'h96;
    run_txn(7'h55, 1'b0, 1, 1'b1, "post_rst");

    // One-clock scl low glitch in the high phase of bit 4 of 0xA5.
    rx_q.delete();
    i2c_start();
    byte_out({TGT, 1'b0}, rd);
    xfer_bit(1'b1, ack);
    check("glitch_addr_ack", ack, 0);
    gbyte = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      if (i == 4) begin
        sda_drv = gbyte[i];
        wait_clks(Q);
        scl_drv = 1'b1;
        wait_clks(Q);
        scl_drv = 1'b0;
        wait_clks(1);
        scl_drv = 1'b1;
        wait_clks(Q);
        scl_drv = 1'b0;
        wait_clks(Q);
      end else begin
        xfer_bit(gbyte[i], s);
      end
    end
    xfer_bit(1'b1, ack);
`ifdef I2C_TARGET_FILTER_EN
    check("glitch_data_ack", ack, 0);
`endif
    i2c_stop();
    wait_clks(2 * Q);
    check("glitch_rx_count", rx_q.size(), 1);
    if (rx_q.size() > 0) begin
`ifdef I2C_TARGET_FILTER_EN
      check("glitch_rx_data", rx_q[0], 8'hA5);
`else
      check("glitch_rx_data", rx_q[0], 8'hA2);
`endif
    end

    for (int t = 0; t < 12; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        ra = 7'($urandom_range(0, 127));
        if (ra == TGT) ra = 7'h56;
      end else begin
        ra = TGT;
      end
      for (int i = 0; i < 4; i++) txn_data[i] = 8'($urandom);
      run_txn(ra, 1'($urandom_range(0, 1)), $urandom_range(1, 3), 1'b1, $sformatf("rnd%0d", t));
    end

    check("pulse_width_overlap", bad_pulse, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
